// File: rtl/fft_clk_pkg.sv
// Shared definitions for the FFT clock-domain reset sequencer.
package fft_clk_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_WAIT_LOCK = 3'd0,
      ST_QUALIFY   = 3'd1,
      ST_HOLD      = 3'd2,
      ST_RUN       = 3'd3,
      ST_PLL_RST   = 3'd4
   } state_t;

   // Largest of four terminal counts; sizes the shared timer.
   function automatic int max_of4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level signal.
module cdc_sync_bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_sr;

   // Shift the asynchronous input through the flop chain; cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) sync_sr <= '0;
      else     sync_sr <= {sync_sr[SYNC_STAGES-2:0], d};
   end

   assign q = sync_sr[SYNC_STAGES-1];

endmodule

// File: rtl/fft_rst_seq.sv
// Lock-qualification and reset sequencer for the FFT clock domain.
// Qualifies PLL lock over a stable window, holds the datapath in reset for a
// fixed time, re-resets on lock loss or soft request, and pulses the PLL reset
// when lock does not arrive within the timeout.
module fft_rst_seq
   import fft_clk_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int LOCK_STABLE  = 1024,
   parameter int RST_HOLD     = 16,
   parameter int LOCK_TIMEOUT = 65536,
   parameter int PLL_RST_CYC  = 8,
   parameter int CNT_W        = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               pll_lock,
   input  logic               soft_rst,
   output logic               pll_rst_req,
   output logic               fft_rst,
   output logic               fft_ready,
   output logic [STATE_W-1:0] state,
   output logic [CNT_W-1:0]   lock_loss_cnt
);

   localparam int TIMER_MAX = max_of4(LOCK_TIMEOUT, LOCK_STABLE, RST_HOLD, PLL_RST_CYC);
   localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

   localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE - 1);
   localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(RST_HOLD - 1);
   localparam logic [TIMER_W-1:0] PLLRST_LAST  = TIMER_W'(PLL_RST_CYC - 1);

   logic               lock_s;
   state_t             cur_state, next_state;
   logic [TIMER_W-1:0] timer, timer_next;
   logic [CNT_W-1:0]   cnt_next;

   cdc_sync_bit #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (pll_lock),
      .q   (lock_s)
   );

   // Next-state, shared timer and lock-loss counter update.
   always_comb begin
      next_state = cur_state;
      cnt_next   = lock_loss_cnt;
      unique case (cur_state)
         ST_WAIT_LOCK: begin
            if (lock_s)                     next_state = ST_QUALIFY;
            else if (timer == TIMEOUT_LAST) next_state = ST_PLL_RST;
         end
         ST_QUALIFY: begin
            if (!lock_s)                    next_state = ST_WAIT_LOCK;
            else if (timer == STABLE_LAST)  next_state = ST_HOLD;
         end
         ST_HOLD: begin
            if (!lock_s)                    next_state = ST_WAIT_LOCK;
            else if (timer == HOLD_LAST)    next_state = ST_RUN;
         end
         ST_RUN: begin
            // Lock loss takes priority over a concurrent soft reset request.
            if (!lock_s) begin
               next_state = ST_WAIT_LOCK;
               if (lock_loss_cnt != {CNT_W{1'b1}}) cnt_next = lock_loss_cnt + 1'b1;
            end else if (soft_rst) begin
               next_state = ST_HOLD;
            end
         end
         ST_PLL_RST: begin
            if (timer == PLLRST_LAST)       next_state = ST_WAIT_LOCK;
         end
         default: next_state = ST_WAIT_LOCK;
      endcase
      // Timer restarts on every state entry and is parked while running so it never wraps.
      if (next_state != cur_state)  timer_next = '0;
      else if (cur_state == ST_RUN) timer_next = timer;
      else                          timer_next = timer + 1'b1;
   end

   // State, timer, counter and registered outputs derived from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state     <= ST_WAIT_LOCK;
         timer         <= '0;
         lock_loss_cnt <= '0;
         fft_rst       <= 1'b1;
         fft_ready     <= 1'b0;
         pll_rst_req   <= 1'b0;
      end else begin
         cur_state     <= next_state;
         timer         <= timer_next;
         lock_loss_cnt <= cnt_next;
         fft_rst       <= (next_state != ST_RUN);
         fft_ready     <= (next_state == ST_RUN);
         pll_rst_req   <= (next_state == ST_PLL_RST);
      end
   end

   assign state = cur_state;

endmodule
